qsn_shift_sched_pc5: RTL and testbench

//  Upstream feeder of the length-5 QSN controller: walks a programmable base-matrix shift table
//  (LAYER_NUM layers x COL_NUM circulant columns) and issues one 3-bit shift_factor per cycle

---
 rtl/qsn_shift_sched_pc5_if.sv | 27 ++
 rtl/qsn_shift_sched_pc5.sv | 105 ++++++++++
 tb/tb_qsn_shift_sched_pc5.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/qsn_shift_sched_pc5_if.sv
// qsn_shift_sched_pc5_if: config, run control and shift-issue channel of the QSN shift scheduler
interface qsn_shift_sched_pc5_if #(
  parameter int ADDR_W = 5,
  parameter int ITER_W = 4
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [2:0]        cfg_data;
  logic [ITER_W-1:0] iter_num;
  logic              start;
  logic              sched_ready;
  logic [2:0]        shift_factor;
  logic              shift_valid;
  logic [2:0]        col_idx;
  logic [1:0]        layer_idx;
  logic              layer_last;
  logic              busy;
  logic              done;
  modport master (
    output cfg_we, cfg_addr, cfg_data, iter_num, start, sched_ready,
    input  shift_factor, shift_valid, col_idx, layer_idx, layer_last, busy, done
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, iter_num, start, sched_ready,
    output shift_factor, shift_valid, col_idx, layer_idx, layer_last, busy, done
  );
endinterface

// File: rtl/qsn_shift_sched_pc5.sv
// qsn_shift_sched_pc5: walks a layer x column shift table and issues one shift per handshake.
// Define QSN_SCHED_DELTA_EN to issue per-column deltas against the previously issued shift.
module qsn_shift_sched_pc5 #(
  parameter int PERMUTATION_LENGTH = 5,
  parameter int LAYER_NUM          = 4,
  parameter int COL_NUM            = 6,
  parameter int ITER_W             = 4
) (
  input logic                  sys_clk,
  input logic                  rstn,
  qsn_shift_sched_pc5_if.slave bus
);
  localparam int DEPTH  = LAYER_NUM * COL_NUM;
  localparam int ADDR_W = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        col_q, col_d;
  logic [1:0]        layer_q, layer_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_num_q, iter_num_d;
  logic [2:0]        tbl_q [DEPTH];
  logic [2:0]        tbl_d [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        cur, sf;
  logic              valid, hs, last_col, last_layer, last_iter, cfg_ok;
  assign valid      = state_q == ISSUE;
  assign hs         = valid & bus.sched_ready;
  assign last_col   = col_q == 3'(COL_NUM - 1);
  assign last_layer = layer_q == 2'(LAYER_NUM - 1);
  assign last_iter  = iter_q == iter_num_q - ITER_W'(1);
  assign rd_addr    = ADDR_W'(int'(layer_q) * COL_NUM + int'(col_q));
  assign cur        = tbl_q[rd_addr];
  assign cfg_ok     = bus.cfg_we && (state_q == IDLE || state_q == DONE) && int'(bus.cfg_addr) < DEPTH;
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    layer_d    = layer_q;
    iter_d     = iter_q;
    iter_num_d = iter_num_q;
    tbl_d      = tbl_q;
    if (cfg_ok)
      tbl_d[bus.cfg_addr] = bus.cfg_data >= 3'(PERMUTATION_LENGTH) ?
                            bus.cfg_data - 3'(PERMUTATION_LENGTH) : bus.cfg_data;
    case (state_q)
      IDLE: if (bus.start) begin
        iter_num_d = bus.iter_num;
        col_d      = '0;
        layer_d    = '0;
        iter_d     = '0;
        state_d    = bus.iter_num == '0 ? DONE : ISSUE;
      end
      ISSUE: if (hs) begin
        col_d   = last_col ? 3'd0 : col_q + 3'd1;
        state_d = last_col ? GAP : ISSUE;
      end
      GAP: begin
        layer_d = last_layer ? 2'd0 : layer_q + 2'd1;
        iter_d  = last_layer ? iter_q + ITER_W'(1) : iter_q;
        state_d = last_layer && last_iter ? DONE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      col_q      <= '0;
      layer_q    <= '0;
      iter_q     <= '0;
      iter_num_q <= '0;
      tbl_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      layer_q    <= layer_d;
      iter_q     <= iter_d;
      iter_num_q <= iter_num_d;
      tbl_q      <= tbl_d;
    end
  end
`ifdef QSN_SCHED_DELTA_EN
  logic [2:0] prev_q [COL_NUM];
  logic [2:0] prev_d [COL_NUM];
  logic [3:0] diff;
  assign diff = 4'(cur) + 4'(PERMUTATION_LENGTH) - 4'(prev_q[col_q]);
  assign sf   = diff >= 4'(PERMUTATION_LENGTH) ? 3'(diff - 4'(PERMUTATION_LENGTH)) : 3'(diff);
  always_comb begin
    prev_d = prev_q;
    if (state_q == IDLE && bus.start) prev_d = '{default: '0};
    else if (hs) prev_d[col_q] = cur;
  end
  always_ff @(posedge sys_clk) begin
    if (!rstn) prev_q <= '{default: '0};
    else prev_q <= prev_d;
  end
`else
  assign sf = cur;
`endif
  assign bus.shift_valid  = valid;
  assign bus.shift_factor = valid ? sf : 3'd0;
  assign bus.col_idx      = col_q;
  assign bus.layer_idx    = layer_q;
  assign bus.layer_last   = valid && last_col;
  assign bus.busy         = state_q == ISSUE || state_q == GAP;
  assign bus.done         = state_q == DONE;
endmodule

// File: tb/tb_qsn_shift_sched_pc5.sv
// tb_qsn_shift_sched_pc5: random-table scoreboard bench for the QSN shift scheduler
module tb_qsn_shift_sched_pc5;
  localparam int L = 4, C = 6, Z = 5;
  logic sys_clk = 0, rstn = 0;
  int total = 0, bad = 0, done_cnt = 0, drop_n = 0, ready_mode = 0;
  bit running = 0, hold_v = 0;
  int held;
  logic [2:0] tbl_m [L*C];
  int exp_q [$];
  qsn_shift_sched_pc5_if #(.ADDR_W(5), .ITER_W(4)) bus ();
  qsn_shift_sched_pc5 dut (.sys_clk(sys_clk), .rstn(rstn), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  function automatic int out_pack();
    return int'({bus.layer_idx, bus.col_idx, bus.shift_factor, bus.layer_last});
  endfunction
  task automatic cfg_write(input int a, input int d);
    @(posedge sys_clk); #1;
    bus.cfg_we = 1; bus.cfg_addr = 5'(a); bus.cfg_data = 3'(d);
    if (!running && a < L*C) tbl_m[a] = 3'(d % Z);
    @(posedge sys_clk); #1;
    bus.cfg_we = 0;
  endtask
  // expected shifts for a whole run, straight from the table contents
  task automatic push_exp(input int iters);
    int prev [C];
    int cur, sf;
    for (int c = 0; c < C; c++) prev[c] = 0;
    for (int it = 0; it < iters; it++)
      for (int l = 0; l < L; l++)
        for (int c = 0; c < C; c++) begin
          cur = int'(tbl_m[l*C + c]);
`ifdef QSN_SCHED_DELTA_EN
          sf = (cur - prev[c] + Z) % Z;
`else
          sf = cur;
`endif
          prev[c] = cur;
          exp_q.push_back((l << 7) | (c << 4) | (sf << 1) | (c == C-1 ? 1 : 0));
        end
  endtask
  task automatic run(input int iters, input int mode);
    int n = 0;
    int d0;
    push_exp(iters);
    ready_mode = mode; drop_n = 0;
    @(posedge sys_clk); #1;
    bus.start = 1; bus.iter_num = 4'(iters); running = 1; d0 = done_cnt;
    @(posedge sys_clk); #1;
    bus.start = 0;
    do begin @(negedge sys_clk); n++; end while (!bus.done && n < 3000);
    running = 0;
    check("done_seen", int'(bus.done), 1);
    if (mode == 0) check("run_cycles", n, iters == 0 ? 1 : iters*L*(C+1) + 1);
    check("busy_at_done", int'(bus.busy), 0);
    @(negedge sys_clk);
    check("done_pulse_width", int'(bus.done), 0);
    check("done_count", done_cnt - d0, 1);
    check("exp_drained", exp_q.size(), 0);
    if (mode == 2) check("drop_cycles", drop_n, 3);
    ready_mode = 0;
  endtask
  always @(posedge sys_clk) begin
    #1;
    if (ready_mode == 1) bus.sched_ready = $urandom_range(0, 3) != 0;
    else if (ready_mode == 2 && bus.shift_valid && bus.col_idx == 3'd3 && drop_n < 3) begin
      bus.sched_ready = 0;
      drop_n++;
    end else bus.sched_ready = 1;
  end
  always @(negedge sys_clk) begin
    if (!rstn) hold_v = 0;
    else begin
      if (hold_v) check("hold_stable", int'({bus.shift_valid, 9'(out_pack())}), held);
      if (bus.shift_valid && bus.sched_ready) begin
        if (exp_q.size() == 0) check("unexpected_shift", out_pack(), -1);
        else check("shift", out_pack(), exp_q.pop_front());
      end
      if (bus.shift_valid) check("valid_busy", int'(bus.busy), 1);
      hold_v = bus.shift_valid && !bus.sched_ready;
      held = int'({bus.shift_valid, 9'(out_pack())});
      if (bus.done) done_cnt++;
    end
  end
  initial begin
    int d0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.iter_num = '0; bus.start = 0;
    bus.sched_ready = 1;
    for (int i = 0; i < L*C; i++) tbl_m[i] = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_outputs", int'({bus.shift_factor, bus.shift_valid, bus.col_idx, bus.layer_idx,
                                 bus.layer_last, bus.busy, bus.done}), 0);
    @(posedge sys_clk); #1;
    rstn = 1;
    cfg_write(0, 7); cfg_write(1, 4); cfg_write(2, 5);
    run(1, 0);
    for (int i = 0; i < L*C; i++) cfg_write(i, int'($urandom_range(0, 7)));
    run(2, 0);
    run(1, 2);
    fork
      run(1, 0);
      begin repeat (6) @(posedge sys_clk); cfg_write(0, 3); end
    join
    run(1, 0);
    run(0, 0);
    // abort a run with reset and make sure the next run starts clean
    push_exp(3);
    @(posedge sys_clk); #1;
    bus.start = 1; bus.iter_num = 4'd3; running = 1; d0 = done_cnt;
    @(posedge sys_clk); #1;
    bus.start = 0;
    repeat (20) @(posedge sys_clk);
    #1 rstn = 0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("midrun_reset_outputs", int'({bus.shift_factor, bus.shift_valid, bus.col_idx, bus.layer_idx,
                                        bus.layer_last, bus.busy, bus.done}), 0);
    @(posedge sys_clk); #1;
    rstn = 1; running = 0;
    exp_q.delete();
    for (int i = 0; i < L*C; i++) tbl_m[i] = '0;
    repeat (5) @(negedge sys_clk);
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", int'(bus.shift_valid), 0);
    cfg_write(0, 6); cfg_write(7, 3);
    run(1, 0);
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 8; w++) cfg_write(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
      run(int'($urandom_range(1, 3)), int'($urandom_range(0, 1)));
    end
    cfg_write(0, 1); cfg_write(6, 4); cfg_write(12, 2); cfg_write(18, 0);
    run(2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
